meat_draw_scheduler: RTL and testbench

- Parametrised successor of the fixed 6-piece meat renderer.
- Owns N_CH rectangular meat sprites. Each sprite has a fat band (top FAT_ROWS rows) and a muscle band (remaining rows), coloured from per-channel inputs.
- Redraws only sprites whose colours changed (dirty tracking), plus a forced full refresh, using round-robin arbitration.
- Streams one pixel per accepted transfer to the VGA adapter over a plot/ready handshake.

---
 rtl/meat_draw_scheduler.sv | 171 +++++++++++++++++
 tb/tb_meat_draw_scheduler.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/meat_draw_scheduler.sv
// Round-robin redraw scheduler for N_CH two-band (fat/muscle) meat sprites.
// Only channels whose colours changed, or that are flagged for refresh, are redrawn.
module meat_draw_scheduler #(
    parameter int N_CH     = 6,
    parameter int COL_W    = 9,
    parameter int XY_W     = 8,
    parameter int BOX_W    = 4,
    parameter int BOX_H    = 3,
    parameter int FAT_ROWS = 1,
    localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_CH*COL_W-1:0]   colour_fat_in,
    input  logic [N_CH*COL_W-1:0]   colour_muscle_in,
    input  logic [N_CH*XY_W-1:0]    x_base,
    input  logic [N_CH*XY_W-1:0]    y_base,
    input  logic                    force_refresh,
    input  logic                    ready,
    output logic                    plot,
    output logic [XY_W-1:0]         x_out,
    output logic [XY_W-1:0]         y_out,
    output logic [COL_W-1:0]        colour_out,
    output logic                    busy,
    output logic [CH_W-1:0]         cur_ch,
    output logic                    ch_done
);

    // plot/ready: a pixel transfers on every cycle where plot and ready are both high.
    // While plot is high and ready is low, x_out/y_out/colour_out hold their values.

    localparam int CW = (BOX_W > 1) ? $clog2(BOX_W) : 1;
    localparam int RW = (BOX_H > 1) ? $clog2(BOX_H) : 1;
    localparam logic [CH_W-1:0] LAST_CH  = CH_W'(N_CH - 1);
    localparam logic [CH_W:0]   N_LIM    = (CH_W + 1)'(N_CH);
    localparam logic [CW-1:0]   LAST_COL = CW'(BOX_W - 1);
    localparam logic [RW-1:0]   LAST_ROW = RW'(BOX_H - 1);
    localparam logic [RW:0]     FAT_LIM  = (RW + 1)'(FAT_ROWS);

    typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;
    state_t state, state_nx;

    logic [COL_W-1:0]  fat_in       [N_CH];
    logic [COL_W-1:0]  muscle_in    [N_CH];
    logic [XY_W-1:0]   xb_in        [N_CH];
    logic [XY_W-1:0]   yb_in        [N_CH];
    logic [COL_W-1:0]  shadow_fat   [N_CH];
    logic [COL_W-1:0]  shadow_muscle[N_CH];
    logic [N_CH-1:0]   refresh_pend;
    logic [N_CH-1:0]   dirty;
    logic [2*N_CH-1:0] dirty2;
    logic [CH_W-1:0]   rr_ptr;
    logic [CH_W-1:0]   grant_ch;
    logic [CH_W:0]     grant_off;
    logic [CH_W:0]     grant_sum;
    logic              grant_vld;
    logic [COL_W-1:0]  snap_fat;
    logic [COL_W-1:0]  snap_muscle;
    logic [XY_W-1:0]   snap_x;
    logic [XY_W-1:0]   snap_y;
    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    logic              accept;
    logic              last_pix;

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            fat_in[i]    = colour_fat_in[i*COL_W +: COL_W];
            muscle_in[i] = colour_muscle_in[i*COL_W +: COL_W];
            xb_in[i]     = x_base[i*XY_W +: XY_W];
            yb_in[i]     = y_base[i*XY_W +: XY_W];
            dirty[i]     = refresh_pend[i] | (fat_in[i] != shadow_fat[i]) |
                           (muscle_in[i] != shadow_muscle[i]);
        end
    end

    // Rotate so bit 0 is rr_ptr; the lowest set bit is the nearest dirty channel at or after it.
    always_comb begin
        dirty2    = {dirty, dirty} >> rr_ptr;
        grant_vld = 1'b0;
        grant_off = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (dirty2[k]) begin
                grant_vld = 1'b1;
                grant_off = (CH_W + 1)'(k);
            end
        end
        grant_sum = {1'b0, rr_ptr} + grant_off;
        grant_ch  = (grant_sum >= N_LIM) ? CH_W'(grant_sum - N_LIM) : grant_sum[CH_W-1:0];
    end

    assign accept   = (state == DRAW) && ready;
    assign last_pix = accept && (col == LAST_COL) && (row == LAST_ROW);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        plot       = 1'b0;
        busy       = 1'b0;
        ch_done    = 1'b0;
        x_out      = snap_x + XY_W'(col);
        y_out      = snap_y + XY_W'(row);
        colour_out = ({1'b0, row} < FAT_LIM) ? snap_fat : snap_muscle;
        case (state)
            IDLE: if (grant_vld) state_nx = DRAW;
            DRAW: begin
                plot = 1'b1;
                busy = 1'b1;
                if (last_pix) state_nx = DONE;
            end
            DONE: begin
                busy     = 1'b1;
                ch_done  = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr       <= '0;
            cur_ch       <= '0;
            snap_fat     <= '0;
            snap_muscle  <= '0;
            snap_x       <= '0;
            snap_y       <= '0;
            col          <= '0;
            row          <= '0;
            refresh_pend <= '1;
            for (int i = 0; i < N_CH; i++) begin
                shadow_fat[i]    <= '0;
                shadow_muscle[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: if (grant_vld) begin
                    cur_ch                 <= grant_ch;
                    snap_fat               <= fat_in[grant_ch];
                    snap_muscle            <= muscle_in[grant_ch];
                    snap_x                 <= xb_in[grant_ch];
                    snap_y                 <= yb_in[grant_ch];
                    refresh_pend[grant_ch] <= 1'b0;
                    col                    <= '0;
                    row                    <= '0;
                end
                DRAW: if (accept) begin
                    if (col == LAST_COL) begin
                        col <= '0;
                        row <= row + 1'b1;
                    end else begin
                        col <= col + 1'b1;
                    end
                end
                DONE: begin
                    // Shadows take the drawn snapshot so mid-draw input changes stay dirty.
                    shadow_fat[cur_ch]    <= snap_fat;
                    shadow_muscle[cur_ch] <= snap_muscle;
                    rr_ptr                <= (cur_ch == LAST_CH) ? '0 : cur_ch + 1'b1;
                end
                default: ;
            endcase
            if (force_refresh) refresh_pend <= '1;
        end
    end

endmodule

// File: tb/tb_meat_draw_scheduler.sv
// Scoreboard bench for meat_draw_scheduler: a sprite-level model predicts every
// pixel and completion; a negedge monitor compares whatever the DUT presents.
module tb_meat_draw_scheduler;

    localparam int N_CH     = 6;
    localparam int COL_W    = 9;
    localparam int XY_W     = 8;
    localparam int BOX_W    = 4;
    localparam int BOX_H    = 3;
    localparam int FAT_ROWS = 1;
    localparam int CH_W     = 3;
    localparam int PW       = CH_W + 2*XY_W + COL_W;
    localparam int NPIX     = BOX_W * BOX_H;
    localparam int TIMEOUT  = 600;
    localparam int XY_MOD   = 1 << XY_W;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic [N_CH*COL_W-1:0] colour_fat_in = '0;
    logic [N_CH*COL_W-1:0] colour_muscle_in = '0;
    logic [N_CH*XY_W-1:0]  x_base = '0;
    logic [N_CH*XY_W-1:0]  y_base = '0;
    logic                  force_refresh = 1'b0;
    logic                  ready = 1'b1;
    logic                  plot;
    logic [XY_W-1:0]       x_out;
    logic [XY_W-1:0]       y_out;
    logic [COL_W-1:0]      colour_out;
    logic                  busy;
    logic [CH_W-1:0]       cur_ch;
    logic                  ch_done;

    meat_draw_scheduler #(
        .N_CH(N_CH), .COL_W(COL_W), .XY_W(XY_W),
        .BOX_W(BOX_W), .BOX_H(BOX_H), .FAT_ROWS(FAT_ROWS)
    ) dut (
        .clk(clk), .reset(reset),
        .colour_fat_in(colour_fat_in), .colour_muscle_in(colour_muscle_in),
        .x_base(x_base), .y_base(y_base),
        .force_refresh(force_refresh), .ready(ready),
        .plot(plot), .x_out(x_out), .y_out(y_out), .colour_out(colour_out),
        .busy(busy), .cur_ch(cur_ch), .ch_done(ch_done)
    );

    // Clock / reset
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [PW-1:0] exp_q[$];
    int            exp_done_q[$];
    int            pix_in_sprite = 0;
    int            ready_mode = 0;
    logic [PW-1:0] mon_got;
    logic [PW-1:0] mon_exp;

    // Ready driver: 0 = always ready, 1 = random backpressure, 2 = stalled
    always @(posedge clk) begin
        #2;
        case (ready_mode)
            0:       ready = 1'b1;
            1:       ready = ($urandom_range(0, 3) != 0);
            default: ready = 1'b0;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    // Monitor: compare every presented pixel against the scoreboard head
    always @(negedge clk) begin
        if (reset) begin
            pix_in_sprite = 0;
        end else begin
            if (plot === 1'b1) begin
                mon_got = {cur_ch, x_out, y_out, colour_out};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL pixel: got ch%0d (%0d,%0d) %h, no pixel required",
                             cur_ch, x_out, y_out, colour_out);
                end else begin
                    mon_exp = exp_q[0];
                    if (mon_got !== mon_exp) begin
                        errors++;
                        $display("FAIL pixel: got ch%0d (%0d,%0d) %h required ch%0d (%0d,%0d) %h",
                                 cur_ch, x_out, y_out, colour_out,
                                 mon_exp[PW-1 -: CH_W], mon_exp[2*XY_W+COL_W-1 -: XY_W],
                                 mon_exp[XY_W+COL_W-1 -: XY_W], mon_exp[COL_W-1:0]);
                    end
                end
                if (ready === 1'b1) begin
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    pix_in_sprite++;
                end
            end
            if (ch_done === 1'b1) begin
                checks++;
                if (exp_done_q.size() == 0) begin
                    errors++;
                    $display("FAIL ch_done: got ch%0d, no completion required", cur_ch);
                end else begin
                    if (int'(cur_ch) != exp_done_q[0]) begin
                        errors++;
                        $display("FAIL ch_done: got ch%0d required ch%0d", cur_ch, exp_done_q[0]);
                    end
                    void'(exp_done_q.pop_front());
                end
                check("sprite_pixels", pix_in_sprite, NPIX);
                pix_in_sprite = 0;
            end
        end
    end

    // Input helpers
    task automatic set_fat(input int ch, input int v);
        colour_fat_in[ch*COL_W +: COL_W] = COL_W'(v);
    endtask
    task automatic set_mus(input int ch, input int v);
        colour_muscle_in[ch*COL_W +: COL_W] = COL_W'(v);
    endtask
    task automatic set_base(input int ch, input int x, input int y);
        x_base[ch*XY_W +: XY_W] = XY_W'(x);
        y_base[ch*XY_W +: XY_W] = XY_W'(y);
    endtask
    function automatic int in_fat(input int ch);
        return int'(colour_fat_in[ch*COL_W +: COL_W]);
    endfunction
    function automatic int in_mus(input int ch);
        return int'(colour_muscle_in[ch*COL_W +: COL_W]);
    endfunction
    function automatic int in_x(input int ch);
        return int'(x_base[ch*XY_W +: XY_W]);
    endfunction
    function automatic int in_y(input int ch);
        return int'(y_base[ch*XY_W +: XY_W]);
    endfunction

    // Sprite-level reference model
    int m_shadow_f[N_CH];
    int m_shadow_m[N_CH];
    bit m_pend[N_CH];
    int m_rr;
    int m_cur;
    int m_snap_f;
    int m_snap_m;

    function automatic void model_reset();
        for (int i = 0; i < N_CH; i++) begin
            m_shadow_f[i] = 0;
            m_shadow_m[i] = 0;
            m_pend[i] = 1'b1;
        end
        m_rr = 0;
        exp_q.delete();
        exp_done_q.delete();
    endfunction

    function automatic bit model_dirty(input int ch);
        return m_pend[ch] || in_fat(ch) != m_shadow_f[ch] || in_mus(ch) != m_shadow_m[ch];
    endfunction

    function automatic void model_force();
        for (int i = 0; i < N_CH; i++) m_pend[i] = 1'b1;
    endfunction

    // Grant the next dirty channel and queue its whole sprite; 0 if nothing is dirty.
    function automatic bit model_grant();
        for (int k = 0; k < N_CH; k++) begin
            int idx = (m_rr + k) % N_CH;
            if (model_dirty(idx)) begin
                m_cur = idx;
                m_snap_f = in_fat(idx);
                m_snap_m = in_mus(idx);
                m_pend[idx] = 1'b0;
                for (int r = 0; r < BOX_H; r++) begin
                    for (int c = 0; c < BOX_W; c++) begin
                        int x = (in_x(idx) + c) % XY_MOD;
                        int y = (in_y(idx) + r) % XY_MOD;
                        int colour = (r < FAT_ROWS) ? m_snap_f : m_snap_m;
                        exp_q.push_back({CH_W'(idx), XY_W'(x), XY_W'(y), COL_W'(colour)});
                    end
                end
                exp_done_q.push_back(idx);
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    function automatic void model_complete();
        m_shadow_f[m_cur] = m_snap_f;
        m_shadow_m[m_cur] = m_snap_m;
        m_rr = (m_cur + 1) % N_CH;
    endfunction

    // Driver tasks
    task automatic wait_done(output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (ch_done !== 1'b1 && cycles < TIMEOUT);
        if (ch_done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL wait_done: no ch_done within %0d cycles, required one", TIMEOUT);
        end
    endtask

    task automatic run_until_idle(output int sprites, output int cycles);
        int c;
        sprites = 0;
        cycles = 0;
        while (sprites < 20 && model_grant()) begin
            wait_done(c);
            cycles += c;
            model_complete();
            sprites++;
        end
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        #1;
        check("idle_busy", busy, 0);
        check("idle_plot", plot, 0);
    endtask

    task automatic apply_and_run(input bit do_force, output int sprites);
        bit g;
        int c;
        int s;
        if (do_force) force_refresh = 1'b1;
        g = model_grant();
        if (do_force) model_force();
        @(posedge clk);
        #1;
        force_refresh = 1'b0;
        sprites = 0;
        if (g) begin
            wait_done(c);
            model_complete();
            sprites = 1;
        end
        run_until_idle(s, c);
        sprites += s;
        settle();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_plot"}, plot, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_ch_done"}, ch_done, 0);
        check({tag, "_cur_ch"}, cur_ch, 0);
        check({tag, "_x_out"}, x_out, 0);
        check({tag, "_y_out"}, y_out, 0);
        check({tag, "_colour_out"}, colour_out, 0);
    endtask

    initial begin
        #1_000_000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        int c;
        int n;
        for (int i = 0; i < N_CH; i++) set_base(i, 10 + i*10, 5 + i*5);
        set_base(5, 254, 25);
        model_reset();

        // Power-on sweep: six sprites, 14 cycles each
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset = 1'b0;
        run_until_idle(s, c);
        check("sweep_sprites", s, 6);
        check("sweep_cycles", c, 84);
        settle();

        // Single colour change on ch3 at (40,20)
        @(posedge clk); #1;
        set_fat(3, 'h1C0);
        apply_and_run(1'b0, s);
        check("ch3_only_sprites", s, 1);

        // Base change alone is not a redraw trigger
        @(posedge clk); #1;
        set_base(0, 12, 7);
        apply_and_run(1'b0, s);
        check("base_only_sprites", s, 0);

        // ch1 and ch4 dirty together with rr_ptr at 4
        @(posedge clk); #1;
        set_fat(1, 'h055);
        set_fat(4, 'h0AA);
        apply_and_run(1'b0, s);
        check("pair_sprites", s, 2);

        // ch2: stall at pixel 5, then change its muscle colour mid-draw
        @(posedge clk); #1;
        set_fat(2, 'h123);
        void'(model_grant());
        n = 0;
        while (pix_in_sprite < 5 && n < TIMEOUT) begin
            @(posedge clk); #1;
            n++;
        end
        check("stall_reach", pix_in_sprite, 5);
        ready_mode = 2;
        repeat (5) begin
            @(posedge clk); #1;
            check("stall_plot", plot, 1);
        end
        check("stall_count", pix_in_sprite, 5);
        set_mus(2, 'h1FF);
        ready_mode = 0;
        wait_done(c);
        model_complete();
        run_until_idle(s, c);
        check("ch2_redraw_sprites", s, 1);
        settle();

        // force_refresh while ch0 is drawing
        @(posedge clk); #1;
        set_fat(0, 'h0F0);
        void'(model_grant());
        repeat (2) @(posedge clk);
        #1;
        force_refresh = 1'b1;
        model_force();
        @(posedge clk); #1;
        force_refresh = 1'b0;
        wait_done(c);
        model_complete();
        run_until_idle(s, c);
        check("force_sweep_sprites", s, 6);
        settle();

        // force_refresh in the same cycle as an IDLE grant
        @(posedge clk); #1;
        set_mus(5, 'h0C3);
        apply_and_run(1'b1, s);
        check("grant_force_sprites", s, 7);

        // Reset in the middle of a draw
        @(posedge clk); #1;
        set_fat(1, 'h1AB);
        void'(model_grant());
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs("midreset");
        reset = 1'b0;
        model_reset();
        run_until_idle(s, c);
        check("midreset_sprites", s, 6);
        check("midreset_cycles", c, 84);
        settle();

        // Randomized rounds with backpressure
        ready_mode = 1;
        for (int it = 0; it < 20; it++) begin
            int nchg;
            @(posedge clk); #1;
            nchg = $urandom_range(0, 3);
            for (int j = 0; j < nchg; j++) begin
                int ch = $urandom_range(0, N_CH - 1);
                if ($urandom_range(0, 1) == 1) set_fat(ch, $urandom_range(0, 511));
                else set_mus(ch, $urandom_range(0, 511));
            end
            if ($urandom_range(0, 3) == 0)
                set_base($urandom_range(0, N_CH - 1), $urandom_range(0, 255), $urandom_range(0, 255));
            apply_and_run($urandom_range(0, 4) == 0, s);
        end
        ready_mode = 0;

        check("pixel_queue_empty", exp_q.size(), 0);
        check("done_queue_empty", exp_done_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
